// File: rtl/mac_tx_fifo_rd_ctrl_if.sv
// Signal bundle between the TX FIFO read controller, the FIFO read port and
// the MAC transmit engine. The master side is the controller.
interface mac_tx_fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH       = 16,
  parameter int COUNT_DATA_WIDTH = 8
);
  logic                        ff_empty;
  logic [COUNT_DATA_WIDTH-1:0] ff_rd_count;
  logic [DATA_WIDTH-1:0]       ff_dout;
  logic                        ff_rd_ack;
  logic                        ff_rd_en;

  logic [DATA_WIDTH-1:0]       tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        tx_sop;
  logic                        tx_eop;
  logic [1:0]                  tx_be;

  modport master (
    input  ff_empty, ff_rd_count, ff_dout, ff_rd_ack, tx_ready,
    output ff_rd_en, tx_data, tx_valid, tx_sop, tx_eop, tx_be
  );

  modport slave (
    output ff_empty, ff_rd_count, ff_dout, ff_rd_ack, tx_ready,
    input  ff_rd_en, tx_data, tx_valid, tx_sop, tx_eop, tx_be
  );
endinterface

// File: rtl/mac_tx_fifo_rd_ctrl.sv
// Read-side controller of the MAC TX FIFO: pulls length-prefixed frames,
// hides the FIFO read latency with a 2-entry skid buffer, drops bad frames.
module mac_tx_fifo_rd_ctrl #(
  parameter int DATA_WIDTH       = 16,
  parameter int COUNT_DATA_WIDTH = 8,
  parameter int START_THRESH     = 0,
  parameter int MAX_FRAME_BYTES  = 1536,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                  rd_clk,
  input  logic                  ainit,
  input  logic                  enable,
  mac_tx_fifo_rd_ctrl_if.master bus,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_WAIT, DATA, DONE, DROP} state_t;

  state_t                state, state_next;
  logic [LEN_WIDTH-1:0]  issued, received, words;
  logic [LEN_WIDTH-1:0]  hdr_len, hdr_words, outstanding;
  logic                  len_odd;
  logic [DATA_WIDTH-1:0] skid_data [2];
  logic [1:0]            skid_be   [2];
  logic [1:0]            skid_sop, skid_eop;
  logic                  head, wr_idx;
  logic [1:0]            occ;
  logic [2:0]            committed;
  logic                  want_read, rd_en, pop, push, last_word, err_next, head_eop;

  assign hdr_len     = bus.ff_dout[LEN_WIDTH-1:0];
  assign hdr_words   = LEN_WIDTH'(({1'b0, hdr_len} + {{LEN_WIDTH{1'b0}}, 1'b1}) >> 1);
  assign outstanding = issued - received;
  assign pop         = bus.tx_valid & bus.tx_ready;
  assign push        = bus.ff_rd_ack & (state == DATA);
  assign last_word   = (received + LEN_WIDTH'(1)) == words;
  assign wr_idx      = head ^ occ[0];
  assign head_eop    = skid_eop[head];
  // Words already in the skid plus the one still in flight from the FIFO.
  assign committed   = 3'(occ) + 3'(outstanding) - {2'b00, pop};

  always_comb begin
    state_next = state;
    want_read  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE:
        if (enable && !bus.ff_empty &&
            bus.ff_rd_count >= COUNT_DATA_WIDTH'(START_THRESH))
          state_next = HDR_RD;
      HDR_RD: begin
        want_read = 1'b1;
        if (!bus.ff_empty) state_next = HDR_WAIT;
      end
      HDR_WAIT:
        if (bus.ff_rd_ack) begin
          if (hdr_len == '0) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else if (hdr_len > LEN_WIDTH'(MAX_FRAME_BYTES)) begin
            state_next = DROP;
          end else begin
            state_next = DATA;
          end
        end
      DATA: begin
        want_read = (issued < words) && (committed < 3'd2);
        if (pop && head_eop) state_next = DONE;
      end
      DONE: state_next = IDLE;
      DROP: begin
        want_read = issued < words;
        if (received == words) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_en = want_read & !bus.ff_empty;

  always_ff @(posedge rd_clk or posedge ainit) begin
    if (ainit) begin
      state     <= IDLE;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      frame_err <= err_next;
    end
  end

  // Counters restart at each header so they index words within one frame.
  always_ff @(posedge rd_clk or posedge ainit) begin
    if (ainit) begin
      issued   <= '0;
      received <= '0;
      words    <= '0;
      len_odd  <= 1'b0;
    end else if (state == HDR_WAIT && bus.ff_rd_ack) begin
      issued   <= '0;
      received <= '0;
      words    <= hdr_words;
      len_odd  <= hdr_len[0];
    end else if (state == DATA || state == DROP) begin
      if (rd_en)         issued   <= issued + LEN_WIDTH'(1);
      if (bus.ff_rd_ack) received <= received + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk or posedge ainit) begin
    if (ainit) begin
      for (int i = 0; i < 2; i++) begin
        skid_data[i] <= '0;
        skid_be[i]   <= '0;
      end
      skid_sop <= '0;
      skid_eop <= '0;
      head     <= 1'b0;
      occ      <= '0;
    end else begin
      if (push) begin
        skid_data[wr_idx] <= bus.ff_dout;
        skid_sop[wr_idx]  <= (received == '0);
        skid_eop[wr_idx]  <= last_word;
        skid_be[wr_idx]   <= (last_word && len_odd) ? 2'b10 : 2'b11;
      end
      head <= head ^ pop;
      occ  <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.ff_rd_en = rd_en;
  assign bus.tx_valid = (occ != 2'd0);
  assign bus.tx_data  = bus.tx_valid ? skid_data[head] : '0;
  assign bus.tx_sop   = bus.tx_valid & skid_sop[head];
  assign bus.tx_eop   = bus.tx_valid & head_eop;
  assign bus.tx_be    = bus.tx_valid ? skid_be[head] : 2'b00;
  assign frame_done   = (state == DONE);
  assign busy         = (state != IDLE);

endmodule

// File: doc/mac_tx_fifo_rd_ctrl.md
Name: mac_tx_fifo_rd_ctrl

Overview:
- Read-side controller for the MAC's dual-clock transmit FIFO, running entirely in the FIFO read clock domain.
- Pulls length-prefixed frames out of the FIFO: a header word carrying the byte length, then ceil(len/2) data words.
- Absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer.
- Presents frames to the MAC transmit engine as a valid/ready stream with sop/eop and last-word byte enables; oversize and zero-length frames are dropped in place.

Parameters:
- DATA_WIDTH, 16, FIFO word width; fixed at 16 because the header/byte-enable scheme assumes 2 bytes per word.
- COUNT_DATA_WIDTH, 8, width of the FIFO read-count input.
- START_THRESH, 0, minimum ff_rd_count before a new frame header is read; 0 means "not empty".
- MAX_FRAME_BYTES, 1536, largest legal frame length in bytes.
- LEN_WIDTH, 16, header length field width.

Ports:
- rd_clk  in  1  FIFO read clock; sole clock of this block.
- ainit  in  1  asynchronous active-high reset.
- enable  in  1  permits starting new frames.
- ff_empty  in  1  FIFO empty flag.
- ff_rd_count  in  COUNT_DATA_WIDTH  FIFO fill level, read side.
- ff_dout  in  DATA_WIDTH  FIFO read data; valid in the cycle ff_rd_ack is high.
- ff_rd_ack  in  1  high one cycle after an accepted read.
- ff_rd_en  out  1  FIFO read request.
- tx_data  out  DATA_WIDTH  frame data word; byte 0 is in [15:8].
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the word this cycle.
- tx_sop  out  1  first word of frame, qualified by tx_valid.
- tx_eop  out  1  last word of frame, qualified by tx_valid.
- tx_be  out  2  byte enables: 2'b11, or 2'b10 on the last word of an odd-length frame.
- frame_done  out  1  one-cycle pulse after a frame's eop handshake.
- frame_err  out  1  one-cycle pulse when a dropped frame finishes draining.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, skid buffer empty, counters 0.
- ainit asserted mid-frame aborts immediately; no completion pulse is generated.
- Read issue rule: ff_rd_en = want_read & !ff_empty.
  - issued counter increments on each ff_rd_en.
  - received counter increments on each ff_rd_ack.
  - outstanding = issued - received, always ≤ 1.
- IDLE: go to HDR_RD when enable & !ff_empty & ff_rd_count ≥ START_THRESH. Dropping enable mid-frame has no effect on the frame in progress.
- HDR_RD: assert ff_rd_en once, then go to HDR_WAIT.
- HDR_WAIT: on ff_rd_ack, latch L = ff_dout[LEN_WIDTH-1:0] and words = (L+1)>>1.
  - If L == 0: pulse frame_err, return to IDLE.
  - Else if L > MAX_FRAME_BYTES: go to DROP.
  - Else: go to DATA.
- DATA:
  - Issue reads while issued < words and (skid_occ + outstanding - pop) < 2, where pop = tx_valid & tx_ready. This sustains 1 word/cycle with tx_ready held high.
  - Each ff_rd_ack word is pushed into the skid buffer, tagged with sop (first word), eop (word == words) and be.
  - tx_* outputs are driven from the skid head.
  - tx_data, tx_sop, tx_eop and tx_be are held stable while tx_valid & !tx_ready.
  - On the eop handshake go to DONE.
- DONE: frame_done = 1 for one cycle, then IDLE.
- DROP: read and discard words words at full rate (gated only by ff_empty), with no tx_valid. When received == words, pulse frame_err and go to IDLE.
- FIFO underrun mid-frame (ff_empty high): reads pause, nothing is duplicated or skipped, and the stream resumes when data returns. tx_valid may gap between words.
- Widths: issued, received and words are LEN_WIDTH bits; no wrap within a frame.
- Headers are consumed strictly in order; the FSM never issues a read beyond the current frame's word count.

Test Plan:
- Header 6, data 0xA1A2,0xB1B2,0xC1C2, tx_ready=1 → 3 consecutive tx_valid cycles; sop on 0xA1A2, eop on 0xC1C2, tx_be=11 throughout; frame_done 1 cycle after the eop handshake; ff_rd_en high for exactly 4 cycles.
- Header 5, 3 words → last word tx_be=2'b10, eop=1; earlier words tx_be=11.
- Header 20, tx_ready low for 5 cycles after word 2 → tx_data held at word 2; ff_rd_en stops with skid occupancy 2; all 10 words delivered in order, none lost or duplicated.
- Header 0 then a valid 4-byte frame → frame_err pulses, no tx_valid for the first frame, second frame delivered normally. Header 2000 → 1000 words drained, no tx_valid, frame_err once, 1001 total reads.
- ff_empty forced high for 3 cycles mid-frame → ff_rd_en low during that window; sequence resumes intact, eop on the correct word.
- ainit pulsed while in DATA → all outputs 0 asynchronously, FSM=IDLE, busy=0; next header is read only after reset releases.
